// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback and produces the datapath write enables, with a memory-ready watchdog.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for run
// FETCH     | latch instruction register
// DECODE    | decoder flags valid; halt detected here
// EXECUTE   | branch/jump/nop retire here; loads/stores go to MEMORY
// MEMORY    | data-memory request held until mem_ready or watchdog expiry
// WRITEBACK | register file write and PC+4, retire
// HALT      | halt instruction seen; sticky until reset
// ERROR     | illegal access or memory timeout; sticky until reset
module multicycle_controller #(
    parameter int COUNT_W    = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic               halt,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write_en,
    output logic               mem_read_en,
    output logic               mem_write_en,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam logic [7:0]         LP_LIMIT = 8'(WAIT_LIMIT);
    localparam logic [COUNT_W-1:0] LP_ONE   = COUNT_W'(1);

    state_t               r_state;
    logic [7:0]           r_wait_cnt;
    logic                 r_mem_load;
    logic [COUNT_W-1:0]   r_instr_count;

    logic                 w_ir_write;
    logic                 w_pc_write;
    logic [1:0]           w_pc_src;
    logic                 w_reg_write_en;
    logic                 w_mem_read_en;
    logic                 w_mem_write_en;
    logic                 w_retire;
    logic                 w_conflict;
    logic                 w_is_mem;

    assign w_conflict = mem_read && mem_write;
    assign w_is_mem   = mem_read || mem_write;

    always_comb begin
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = 2'd0;
        w_reg_write_en = 1'b0;
        w_mem_read_en  = 1'b0;
        w_mem_write_en = 1'b0;
        w_retire       = 1'b0;
        case (r_state)
            S_FETCH: w_ir_write = 1'b1;
            S_EXECUTE: begin
                if (w_conflict) begin
                    w_retire = 1'b0;
                end else if (jump) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 2'd2;
                    w_retire   = 1'b1;
                end else if (branch) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = zero ? 2'd1 : 2'd0;
                    w_retire   = 1'b1;
                end else if (!w_is_mem && !reg_write) begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                end
            end
            S_MEMORY: begin
                w_mem_read_en  = r_mem_load;
                w_mem_write_en = !r_mem_load;
                if (mem_ready && !r_mem_load) begin
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                end
            end
            S_WRITEBACK: begin
                w_reg_write_en = 1'b1;
                w_pc_write     = 1'b1;
                w_retire       = 1'b1;
            end
            default: w_retire = 1'b0;
        endcase
    end

    // Reset blanks every strobe so nothing partial reaches the datapath in the reset cycle.
    assign ir_write     = w_ir_write     && !RST;
    assign pc_write     = w_pc_write     && !RST;
    assign pc_src       = RST ? 2'd0 : w_pc_src;
    assign reg_write_en = w_reg_write_en && !RST;
    assign mem_read_en  = w_mem_read_en  && !RST;
    assign mem_write_en = w_mem_write_en && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_mem_load    <= 1'b0;
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + LP_ONE;
            r_state       <= run ? S_FETCH : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (run) r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= halt ? S_HALT : S_EXECUTE;
                S_EXECUTE: begin
                    if (w_conflict) begin
                        r_state <= S_ERROR;
                    end else if (w_is_mem) begin
                        r_state    <= S_MEMORY;
                        r_wait_cnt <= 8'd0;
                        r_mem_load <= mem_read;
                    end else if (reg_write) begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        r_state <= S_WRITEBACK;
                    end else if (r_wait_cnt == LP_LIMIT) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state       = r_state;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERROR);
    assign halted      = (r_state == S_HALT);
    assign error       = (r_state == S_ERROR);
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares state, enables and retire count against hand-computed values.
module tb_multicycle_controller;

    localparam int COUNT_W    = 4;
    localparam int WAIT_LIMIT = 15;

    // enable vector layout: {ir_write, pc_write, pc_src[1:0], reg_write_en, mem_read_en, mem_write_en}
    localparam logic [6:0] EN_NONE = 7'b0000000;
    localparam logic [6:0] EN_IR   = 7'b1000000;
    localparam logic [6:0] EN_PC0  = 7'b0100000;
    localparam logic [6:0] EN_PC1  = 7'b0101000;
    localparam logic [6:0] EN_PC2  = 7'b0110000;
    localparam logic [6:0] EN_WB   = 7'b0100100;
    localparam logic [6:0] EN_MR   = 7'b0000010;
    localparam logic [6:0] EN_MW   = 7'b0000001;
    localparam logic [6:0] EN_MWPC = 7'b0100001;

    logic CLK = 1'b0;
    logic RST, run, branch, jump, zero, mem_read, mem_write, reg_write, halt, mem_ready;
    logic ir_write, pc_write, reg_write_en, mem_read_en, mem_write_en, busy, halted, error;
    logic [1:0]         pc_src;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_count;
    logic [6:0]         w_en;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller #(.COUNT_W(COUNT_W), .WAIT_LIMIT(WAIT_LIMIT)) u_dut (
        .CLK(CLK), .RST(RST), .run(run), .branch(branch), .jump(jump), .zero(zero),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .halt(halt),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write_en(reg_write_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .state(state), .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
    );

    assign w_en = {ir_write, pc_write, pc_src, reg_write_en, mem_read_en, mem_write_en};

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] exp_state, input logic [6:0] exp_en);
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".en"}, 32'(w_en), 32'(exp_en));
    endtask

    task automatic set_flags(input logic b, input logic j, input logic z, input logic mr,
                             input logic mw, input logic rw, input logic h);
        branch = b; jump = j; zero = z; mem_read = mr; mem_write = mw; reg_write = rw; halt = h;
    endtask

    initial begin
        RST = 1'b1; run = 1'b0; mem_ready = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_st("rst", 3'd0, EN_NONE);
        check("rst.busy", 32'(busy), 0);
        check("rst.halted", 32'(halted), 0);
        check("rst.error", 32'(error), 0);
        check("rst.count", 32'(instr_count), 0);
        RST = 1'b0;
        tick();
        chk_st("idle_norun", 3'd0, EN_NONE);

        // ALU instruction with writeback
        set_flags(0, 0, 0, 0, 0, 1, 0);
        run = 1'b1;
        tick(); chk_st("alu.c1", 3'd1, EN_IR);
        check("alu.busy", 32'(busy), 1);
        tick(); chk_st("alu.c2", 3'd2, EN_NONE);
        tick(); chk_st("alu.c3", 3'd3, EN_NONE);
        tick(); chk_st("alu.c4", 3'd5, EN_WB);
        tick(); chk_st("alu.next", 3'd1, EN_IR);
        check("alu.count", 32'(instr_count), 1);

        // branch taken, not taken, then jump winning over branch
        set_flags(1, 0, 1, 0, 0, 0, 0);
        tick(); tick(); chk_st("brt.ex", 3'd3, EN_PC1);
        tick(); chk_st("brt.next", 3'd1, EN_IR);
        check("brt.count", 32'(instr_count), 2);
        set_flags(1, 0, 0, 0, 0, 0, 0);
        tick(); tick(); chk_st("brn.ex", 3'd3, EN_PC0);
        tick(); check("brn.count", 32'(instr_count), 3);
        set_flags(1, 1, 1, 0, 0, 0, 0);
        tick(); tick(); chk_st("jmp.ex", 3'd3, EN_PC2);
        tick(); chk_st("jmp.next", 3'd1, EN_IR);
        check("jmp.count", 32'(instr_count), 4);

        // load, three not-ready MEMORY cycles then ready: 8 cycles total
        set_flags(0, 0, 0, 1, 0, 1, 0);
        mem_ready = 1'b0;
        tick(); chk_st("ld.dec", 3'd2, EN_NONE);
        tick(); chk_st("ld.ex", 3'd3, EN_NONE);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_st($sformatf("ld.m%0d", i), 3'd4, EN_MR);
        end
        tick(); mem_ready = 1'b1; chk_st("ld.m3", 3'd4, EN_MR);
        tick(); mem_ready = 1'b0; chk_st("ld.wb", 3'd5, EN_WB);
        tick(); chk_st("ld.next", 3'd1, EN_IR);
        check("ld.count", 32'(instr_count), 5);

        // store, ready after one low cycle: retires from MEMORY
        set_flags(0, 0, 0, 0, 1, 0, 0);
        tick(); tick(); tick(); chk_st("st.m0", 3'd4, EN_MW);
        tick(); mem_ready = 1'b1; chk_st("st.m1", 3'd4, EN_MWPC);
        tick(); mem_ready = 1'b0; chk_st("st.next", 3'd1, EN_IR);
        check("st.count", 32'(instr_count), 6);

        // store with mem_ready never asserted: watchdog
        tick(); tick();
        for (int i = 0; i <= WAIT_LIMIT; i++) begin
            tick(); chk_st($sformatf("wd.m%0d", i), 3'd4, EN_MW);
        end
        tick(); chk_st("wd.err", 3'd7, EN_NONE);
        check("wd.error", 32'(error), 1);
        check("wd.busy", 32'(busy), 0);
        mem_ready = 1'b1;
        tick(); tick(); chk_st("wd.sticky", 3'd7, EN_NONE);
        check("wd.count", 32'(instr_count), 6);
        mem_ready = 1'b0;
        RST = 1'b1;
        tick(); chk_st("wd.rst", 3'd0, EN_NONE);
        check("wd.rstcount", 32'(instr_count), 0);
        RST = 1'b0;

        // halt in DECODE
        set_flags(0, 0, 0, 0, 0, 0, 1);
        tick(); chk_st("hlt.f", 3'd1, EN_IR);
        tick(); tick(); chk_st("hlt.st", 3'd6, EN_NONE);
        check("hlt.halted", 32'(halted), 1);
        check("hlt.busy", 32'(busy), 0);
        tick(); chk_st("hlt.sticky", 3'd6, EN_NONE);
        check("hlt.count", 32'(instr_count), 0);
        RST = 1'b1;
        tick(); chk_st("hlt.rst", 3'd0, EN_NONE);
        RST = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0, 0);
        tick(); chk_st("hlt.refetch", 3'd1, EN_IR);

        // 16 nops wrap the 4-bit counter
        for (int i = 1; i <= 16; i++) begin
            tick(); tick(); tick();
            check($sformatf("wrap.%0d", i), 32'(instr_count), 32'(i % 16));
        end
        chk_st("wrap.fetch", 3'd1, EN_IR);

        // run dropped mid-instruction: finish then IDLE
        tick(); tick(); run = 1'b0;
        chk_st("stop.ex", 3'd3, EN_PC0);
        tick(); chk_st("stop.idle", 3'd0, EN_NONE);
        check("stop.count", 32'(instr_count), 1);
        tick(); chk_st("stop.stay", 3'd0, EN_NONE);

        // reset during MEMORY: no enable in the reset cycle
        run = 1'b1;
        set_flags(0, 0, 0, 1, 0, 1, 0);
        tick(); tick(); tick(); tick(); chk_st("rm.mem", 3'd4, EN_MR);
        RST = 1'b1;
        chk_st("rm.rstcyc", 3'd4, EN_NONE);
        tick(); chk_st("rm.idle", 3'd0, EN_NONE);
        check("rm.count", 32'(instr_count), 0);
        RST = 1'b0;

        // load and store both set: ERROR from EXECUTE
        set_flags(0, 0, 0, 1, 1, 0, 0);
        tick(); tick(); tick(); chk_st("conf.ex", 3'd3, EN_NONE);
        tick(); chk_st("conf.err", 3'd7, EN_NONE);
        check("conf.error", 32'(error), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the decode/execute datapath: walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states and generates the per-cycle write enables for the datapath.
- Write enables driven: instruction register, PC, register file and data memory.
- Sits between the instruction decoder (class flags in) and the fetch/register/data-memory write ports (enables out).
- Adds a data-memory ready handshake with watchdog, a halt state and a retired-instruction counter.

## Interface
Parameters:
- COUNT_W, 16, width of retired-instruction counter
- WAIT_LIMIT, 15, max MEMORY cycles without mem_ready before ERROR (1..255)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- run  in  1  1 = keep issuing instructions; sampled in IDLE and at retire
- branch  in  1  decoded: conditional branch
- jump  in  1  decoded: jump
- zero  in  1  ALU zero flag, valid in EXECUTE
- mem_read  in  1  decoded: load
- mem_write  in  1  decoded: store
- reg_write  in  1  decoded: writes register file
- halt  in  1  decoded: halt instruction
- mem_ready  in  1  data memory completed access (one-cycle pulse or level)
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_write_en  out  1  register file write strobe
- mem_read_en  out  1  data memory read request
- mem_write_en  out  1  data memory write request
- state  out  3  current state encoding
- busy  out  1  state not IDLE/HALT/ERROR
- halted  out  1  state == HALT
- error  out  1  state == ERROR
- instr_count  out  COUNT_W  retired instructions

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7. State and counters are registered; enables are combinational from state and inputs.
- While RST is high, all enables are forced to 0.
- IDLE: all enables 0; run=1 -> FETCH.
- FETCH: ir_write=1 -> DECODE.
- DECODE: halt=1 -> HALT; otherwise -> EXECUTE. Decoder flags are trusted from this cycle on.
- EXECUTE, in priority order:
  - mem_read and mem_write both 1 -> ERROR.
  - jump -> pc_write=1, pc_src=2, retire. Jump wins over branch.
  - branch -> pc_write=1, pc_src = zero ? 1 : 0, retire.
  - mem_read or mem_write -> MEMORY; wait counter cleared.
  - reg_write -> WRITEBACK.
  - otherwise -> pc_write=1, pc_src=0, retire (nop).
- MEMORY: mem_read_en/mem_write_en held at 1 (per access type) every cycle in state.
  - mem_ready=1, load -> WRITEBACK.
  - mem_ready=1, store -> pc_write=1, pc_src=0, retire.
  - mem_ready=0 -> wait counter +1. If counter already equals WAIT_LIMIT -> ERROR.
- WRITEBACK: reg_write_en=1, pc_write=1, pc_src=0, retire.
- Retire: instr_count += 1 (wraps modulo 2^COUNT_W); next state FETCH if run=1, else IDLE.
- HALT and ERROR are sticky until RST. All enables are 0 there; halt instructions are not counted.
- mem_ready outside MEMORY is ignored.

## Timing
- Reset values: state=IDLE, every enable 0, pc_src=0, busy=0, halted=0, error=0, instr_count=0, wait counter=0.
- Latency from FETCH entry to retire (inclusive):
  - jump/branch/nop: 3 cycles
  - R-type/immediate ALU: 4 cycles
  - store: 4+w cycles
  - load: 5+w cycles
  - w = MEMORY cycles with mem_ready low before the ready cycle.
- Back-to-back: with run=1, FETCH of the next instruction is the cycle after retire. No idle bubble.
- Memory watchdog: mem_ready is accepted in MEMORY cycle indices 0..WAIT_LIMIT. No ready by index WAIT_LIMIT -> ERROR next cycle.
- Reset mid-operation: on the RST edge the state returns to IDLE and instr_count clears. No partial write is issued in the RST cycle.
- run deassert mid-instruction: the current instruction completes, then IDLE.

## Test plan
- ALU instruction, run=1, reg_write=1: the FETCH..WRITEBACK sequence shows ir_write on cycle 1 and reg_write_en+pc_write on cycle 4. instr_count becomes 1 and FETCH follows immediately.
- Taken branch with zero=1: pc_write=1, pc_src=1 in EXECUTE, 3-cycle retire. Repeat with zero=0: pc_src=0. Repeat with jump=1, branch=1: pc_src=2.
- Load with mem_ready after 3 low cycles: mem_read_en high for 4 MEMORY cycles, then WRITEBACK asserts reg_write_en. Total 8 cycles.
- Store with mem_ready never asserted, WAIT_LIMIT=15: mem_write_en high for 16 cycles, then state=7, error=1, all enables 0 until RST.
- halt in DECODE: state=6, halted=1, busy=0, instr_count unchanged. RST then returns state=0; with run=1 the next cycle is FETCH.
- RST during MEMORY, and COUNT_W=4 with 16 retirements: RST clears to IDLE with no enable in the RST cycle. The counter wraps 15 -> 0.
